// File: rtl/tap2_host_sm.sv
// tap2_host_sm: host-side 2-wire TAP2 packet generator driving the shared TMS wire.
// Build option: define TAP2_HOST_PAR_CHK_EN to flag read parity mismatches on rsp_par_err.
module tap2_host_sm #(
  parameter int RST_CYCLES = 81,
  parameter int DR_LEN     = 32,
  parameter int IR_LEN     = 8
) (
  input  logic        tclk,
  input  logic        trst_b,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_rw,
  input  logic [1:0]  req_rs,
  input  logic [31:0] req_wdata,
  input  logic        rst_req,
  output logic        tms_o,
  output logic        tms_oe,
  input  logic        tms_i,
  output logic        rsp_vld,
  output logic [31:0] rsp_rdata,
  output logic        rsp_par_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_RSTSEQ, S_START, S_RW, S_RS, S_TRN1, S_SYNC, S_DATA, S_PARITY, S_TRN2
  } state_e;

  localparam logic [6:0] RST_LOAD = 7'(RST_CYCLES - 1);
  localparam logic [7:0] DR_LAST  = 8'(DR_LEN - 1);
  localparam logic [7:0] IR_LAST  = 8'(IR_LEN - 1);

  state_e      state_q, state_d;
  logic [6:0]  rst_cnt_q, rst_cnt_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic        rs_sel_q, rs_sel_d;
  logic        rw_q, rw_d;
  logic [1:0]  rs_q, rs_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_sh_q, rd_sh_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        tms_q, tms_d;
  logic        oe_q, oe_d;

  logic [7:0]  len_last;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] wmask;
  logic        wpar;

  assign len_last = rs_q[0] ? DR_LAST : IR_LAST;
  // DATA goes out LSB first while the bit counter runs down to zero
  assign idx_q    = 5'(len_last - bit_cnt_q);
  assign idx_d    = 5'(len_last - bit_cnt_d);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 32; i++) begin
      if (8'(i) <= len_last) wmask[i] = 1'b1;
    end
  end

  assign wpar = ^(wdata_q & wmask);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    bit_cnt_d = bit_cnt_q;
    rs_sel_d  = rs_sel_q;
    rw_d      = rw_q;
    rs_d      = rs_q;
    wdata_d   = wdata_q;
    rd_sh_d   = rd_sh_q;
    rdata_d   = rdata_q;
    rsp_vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst_req) begin
          state_d   = S_RSTSEQ;
          rst_cnt_d = RST_LOAD;
        end else if (req_vld) begin
          state_d = S_START;
          rw_d    = req_rw;
          rs_d    = req_rs;
          wdata_d = req_wdata;
          rd_sh_d = '0;
        end
      end
      S_RSTSEQ: begin
        if (rst_cnt_q == 7'd0) state_d = S_IDLE;
        else                   rst_cnt_d = rst_cnt_q - 7'd1;
      end
      S_START: state_d = S_RW;
      S_RW: begin
        state_d  = S_RS;
        rs_sel_d = 1'b0;
      end
      S_RS: begin
        if (rs_sel_q) state_d = S_TRN1;
        else          rs_sel_d = 1'b1;
      end
      S_TRN1: begin
        state_d   = rw_q ? S_SYNC : S_DATA;
        bit_cnt_d = len_last;
      end
      S_SYNC: state_d = S_DATA;
      S_DATA: begin
        if (rw_q) rd_sh_d[idx_q] = tms_i;
        if (bit_cnt_q == 8'd0) state_d = S_PARITY;
        else                   bit_cnt_d = bit_cnt_q - 8'd1;
      end
      S_PARITY: state_d = S_TRN2;
      S_TRN2: begin
        state_d   = S_IDLE;
        rsp_vld_d = 1'b1;
        if (rw_q) rdata_d = rd_sh_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wire value is registered against the next state so each field lands in its own cycle
  always_comb begin
    tms_d = 1'b1;
    oe_d  = 1'b1;
    case (state_d)
      S_START: tms_d = 1'b0;
      S_RW:    tms_d = rw_q;
      S_RS:    tms_d = rs_sel_d ? rs_q[1] : rs_q[0];
      S_TRN1:  oe_d  = ~rw_q;
      S_SYNC:  oe_d  = 1'b0;
      S_DATA: begin
        if (rw_q) oe_d  = 1'b0;
        else      tms_d = wdata_q[idx_d];
      end
      S_PARITY: begin
        if (rw_q) oe_d  = 1'b0;
        else      tms_d = wpar;
      end
      S_TRN2:  oe_d  = ~rw_q;
      default: ;
    endcase
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      bit_cnt_q <= '0;
      rs_sel_q  <= 1'b0;
      rw_q      <= 1'b0;
      rs_q      <= '0;
      wdata_q   <= '0;
      rd_sh_q   <= '0;
      rdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      tms_q     <= 1'b1;
      oe_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rs_sel_q  <= rs_sel_d;
      rw_q      <= rw_d;
      rs_q      <= rs_d;
      wdata_q   <= wdata_d;
      rd_sh_q   <= rd_sh_d;
      rdata_q   <= rdata_d;
      rsp_vld_q <= rsp_vld_d;
      tms_q     <= tms_d;
      oe_q      <= oe_d;
    end
  end

`ifdef TAP2_HOST_PAR_CHK_EN
  logic rpar_q;
  logic par_err_q;

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      rpar_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (state_q == S_PARITY && rw_q) rpar_q <= tms_i;
      par_err_q <= (state_q == S_TRN2) && rw_q && (rpar_q != ^rd_sh_q);
    end
  end

  assign rsp_par_err = par_err_q;
`else
  assign rsp_par_err = 1'b0;
`endif

  assign req_rdy   = (state_q == S_IDLE) && !rst_req;
  assign busy      = (state_q != S_IDLE);
  assign tms_o     = tms_q;
  assign tms_oe    = oe_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_tap2_host_sm.sv
// tb_tap2_host_sm: directed packets checked by a scoreboard against a TAP2 target model on the wire.
// Read parity expectation follows TAP2_HOST_PAR_CHK_EN.
module tb_tap2_host_sm;

  logic        tclk = 1'b0;
  logic        trst_b;
  logic        req_vld;
  logic        req_rdy;
  logic        req_rw;
  logic [1:0]  req_rs;
  logic [31:0] req_wdata;
  logic        rst_req;
  logic        tms_o;
  logic        tms_oe;
  logic        tms_i;
  logic        rsp_vld;
  logic [31:0] rsp_rdata;
  logic        rsp_par_err;
  logic        busy;
  logic        wire_v;

  always #5 tclk = ~tclk;

  tap2_host_sm dut (
    .tclk(tclk), .trst_b(trst_b), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_rw(req_rw), .req_rs(req_rs), .req_wdata(req_wdata), .rst_req(rst_req),
    .tms_o(tms_o), .tms_oe(tms_oe), .tms_i(tms_i), .rsp_vld(rsp_vld),
    .rsp_rdata(rsp_rdata), .rsp_par_err(rsp_par_err), .busy(busy)
  );

  assign wire_v = tms_oe ? tms_o : tms_i;

`ifdef TAP2_HOST_PAR_CHK_EN
  localparam logic PERR_BAD = 1'b1;
`else
  localparam logic PERR_BAD = 1'b0;
`endif

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] wdata;
    logic [31:0] rd_val;
    logic        rd_par;
    logic [4:0]  hdr;
    logic [31:0] data;
    logic        par;
    logic [31:0] rdata;
    logic        perr;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic        par;
  } rd_t;

  vec_t sb_q[$];
  rd_t  tgt_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Target model: follows the packet on the wire at negedge, supplies read data, tracks reset
  typedef enum int {M_IDLE, M_RW, M_RS0, M_RS1, M_TRN1, M_SYNC, M_DATA, M_PAR, M_TRN2} mph_e;
  mph_e        mph;
  int          hi_cnt, m_cnt, m_len, tgt_pkts;
  logic        tgt_reset;
  logic        m_rw, m_rs0, m_par, m_oe_bad, m_rd_par;
  logic [4:0]  m_hdr, tgt_hdr;
  logic [31:0] m_data, m_rd_val, tgt_data;
  logic        tgt_par, tgt_oe_bad;

  initial begin
    rd_t rd;
    mph = M_IDLE; tms_i = 1'b1; hi_cnt = 0; tgt_reset = 1'b0; tgt_pkts = 0;
    m_rw = 0; m_rs0 = 0; m_par = 0; m_oe_bad = 0; m_hdr = '0; m_data = '0;
    m_rd_val = '0; m_rd_par = 0; m_cnt = 0; m_len = 8;
    tgt_hdr = '0; tgt_data = '0; tgt_par = 0; tgt_oe_bad = 0;
    forever begin
      @(negedge tclk);
      if (wire_v) begin
        if (hi_cnt < 1000) hi_cnt++;
        if (hi_cnt == 81) tgt_reset = 1'b1;
      end else hi_cnt = 0;
      if (!trst_b) begin
        mph = M_IDLE;
        tms_i = 1'b1;
      end else begin
        case (mph)
          M_IDLE: if (!wire_v) begin
            mph = M_RW; m_hdr = '0; m_data = '0; m_par = 0; tgt_reset = 1'b0;
            m_oe_bad = !tms_oe;
          end
          M_RW: begin
            m_rw = wire_v; m_hdr = {m_hdr[3:0], wire_v};
            if (!tms_oe) m_oe_bad = 1'b1;
            mph = M_RS0;
          end
          M_RS0: begin
            m_rs0 = wire_v; m_hdr = {m_hdr[3:0], wire_v};
            if (!tms_oe) m_oe_bad = 1'b1;
            mph = M_RS1;
          end
          M_RS1: begin
            m_hdr = {m_hdr[3:0], wire_v};
            if (!tms_oe) m_oe_bad = 1'b1;
            mph = M_TRN1;
          end
          M_TRN1: begin
            m_hdr = {m_hdr[3:0], wire_v};
            if (tms_oe !== !m_rw) m_oe_bad = 1'b1;
            m_len = m_rs0 ? 32 : 8;
            m_cnt = 0;
            if (m_rw) begin
              if (tgt_q.size() > 0) begin
                rd = tgt_q.pop_front();
                m_rd_val = rd.val; m_rd_par = rd.par;
              end else begin
                m_rd_val = '0; m_rd_par = 1'b0;
              end
              mph = M_SYNC;
            end else mph = M_DATA;
          end
          M_SYNC: begin
            if (tms_oe !== 1'b0) m_oe_bad = 1'b1;
            mph = M_DATA;
          end
          M_DATA: begin
            if (tms_oe !== !m_rw) m_oe_bad = 1'b1;
            if (m_rw) tms_i = m_rd_val[m_cnt];
            else      m_data[m_cnt] = wire_v;
            m_cnt++;
            if (m_cnt == m_len) mph = M_PAR;
          end
          M_PAR: begin
            if (tms_oe !== !m_rw) m_oe_bad = 1'b1;
            if (m_rw) tms_i = m_rd_par;
            else      m_par = wire_v;
            mph = M_TRN2;
          end
          M_TRN2: begin
            if (tms_oe !== !m_rw) m_oe_bad = 1'b1;
            tms_i = 1'b1;
            tgt_hdr = m_hdr; tgt_data = m_data; tgt_par = m_par; tgt_oe_bad = m_oe_bad;
            tgt_pkts++;
            mph = M_IDLE;
          end
          default: mph = M_IDLE;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every response pulse
  initial begin
    vec_t e;
    int run, last_run;
    run = 0; last_run = 0;
    forever begin
      @(negedge tclk);
      if (busy) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (rsp_vld) begin
        rsp_cnt++;
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp_vld with rdata %h, expected no response", rsp_rdata);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_par_err", 32'(rsp_par_err), 32'(e.perr));
          chk("pkt_cycles", 32'(last_run), 32'(e.cycles));
          chk("hdr_bits", 32'(tgt_hdr), 32'(e.hdr));
          chk("oe_profile", 32'(tgt_oe_bad), 32'd0);
          if (!e.rw) begin
            chk("wr_data", tgt_data, e.data);
            chk("wr_parity", 32'(tgt_par), 32'(e.par));
          end
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit track);
    int n;
    if (track) sb_q.push_back(v);
    if (v.rw) tgt_q.push_back('{v.rd_val, v.rd_par});
    @(negedge tclk);
    req_vld = 1'b1; req_rw = v.rw; req_rs = v.rs; req_wdata = v.wdata;
    n = 0;
    while (!req_rdy && n < 300) begin
      @(negedge tclk);
      n++;
    end
    if (!req_rdy) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept: req_rdy stayed %b, expected 1 within 300 cycles", req_rdy);
    end
    @(posedge tclk);
    #1 req_vld = 1'b0;
  endtask

  task automatic count_rstseq(output int cnt, output bit hi_bad);
    cnt = 0; hi_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tclk);
      if (req_rdy) break;
      cnt++;
      if (tms_o !== 1'b1 || tms_oe !== 1'b1) hi_bad = 1'b1;
    end
  endtask

  // rw, rs, wdata, rd_val, rd_par, hdr, data, par, rdata, perr, cycles
  vec_t vecs[8];
  initial begin
    vecs[0] = '{1'b0, 2'b01, 32'hA5A5_0F0F, 32'h0, 1'b0, 5'b00101, 32'hA5A5_0F0F, 1'b0, 32'h0, 1'b0, 39};
    vecs[1] = '{1'b0, 2'b00, 32'h0000_0081, 32'h0, 1'b0, 5'b00001, 32'h0000_0081, 1'b0, 32'h0, 1'b0, 15};
    vecs[2] = '{1'b1, 2'b11, 32'h0, 32'h1234_5678, 1'b1, 5'b01111, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 40};
    vecs[3] = '{1'b1, 2'b10, 32'h0, 32'h0000_003C, 1'b1, 5'b01011, 32'h0, 1'b0, 32'h0000_003C, PERR_BAD, 16};
    vecs[4] = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'b00111, 32'hFFFF_FFFF, 1'b0, 32'h0000_003C, 1'b0, 39};
    vecs[5] = '{1'b1, 2'b01, 32'h0, 32'h8000_0001, 1'b0, 5'b01101, 32'h0, 1'b0, 32'h8000_0001, 1'b0, 40};
    vecs[6] = '{1'b0, 2'b10, 32'hABCD_12FE, 32'h0, 1'b0, 5'b00011, 32'h0000_00FE, 1'b1, 32'h8000_0001, 1'b0, 15};
    vecs[7] = '{1'b1, 2'b00, 32'h0, 32'hFFFF_FF5A, 1'b0, 5'b01001, 32'h0, 1'b0, 32'h0000_005A, 1'b0, 16};
  end

  initial begin
    int   cnt, saved, n;
    bit   hi_bad;
    vec_t v;
    trst_b = 1'b0; req_vld = 1'b0; req_rw = 1'b0; req_rs = '0; req_wdata = '0; rst_req = 1'b0;
    repeat (3) @(negedge tclk);
    chk("reset_outs", 32'({tms_o, tms_oe, rsp_vld, busy, rsp_par_err, req_rdy}), 32'b110001);
    chk("reset_rdata", rsp_rdata, 32'h0);
    trst_b = 1'b1;
    repeat (2) @(negedge tclk);
    chk("tgt_not_reset", 32'(tgt_reset), 32'd0);

    rst_req = 1'b1;
    @(posedge tclk);
    #1 rst_req = 1'b0;
    count_rstseq(cnt, hi_bad);
    chk("rstseq_len", 32'(cnt), 32'd81);
    chk("rstseq_high", 32'(hi_bad), 32'd0);
    chk("tgt_reset", 32'(tgt_reset), 32'd1);

    foreach (vecs[i]) send(vecs[i], 1'b1);
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge tclk); n++; end
    repeat (3) @(negedge tclk);

    // Abort a read in the middle of its DATA field
    v = '{1'b1, 2'b01, 32'h0, 32'hDEAD_BEEF, 1'b0, 5'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0};
    saved = rsp_cnt;
    send(v, 1'b0);
    repeat (20) @(negedge tclk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    trst_b = 1'b0;
    #1 chk("abort_outs", 32'({tms_o, tms_oe, busy, rsp_vld}), 32'b1100);
    repeat (2) @(negedge tclk);
    trst_b = 1'b1;
    repeat (60) @(negedge tclk);
    chk("abort_no_rsp", 32'(rsp_cnt), 32'(saved));

    // Reset sequence wins over a simultaneous request
    v = '{1'b0, 2'b00, 32'h0000_0055, 32'h0, 1'b0, 5'b00001, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 15};
    sb_q.push_back(v);
    @(negedge tclk);
    rst_req = 1'b1; req_vld = 1'b1; req_rw = v.rw; req_rs = v.rs; req_wdata = v.wdata;
    #1 chk("rdy_masked", 32'(req_rdy), 32'd0);
    @(posedge tclk);
    #1 rst_req = 1'b0;
    count_rstseq(cnt, hi_bad);
    chk("rstseq2_len", 32'(cnt), 32'd81);
    @(posedge tclk);
    #1 req_vld = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge tclk); n++; end
    repeat (3) @(negedge tclk);
    chk("drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tap2_host_sm.md
Name: tap2_host_sm

Overview:
- Host-side (initiator) 2-wire TAP2 packet generator: serialises one debug access per request onto the single TMS wire.
- Sits in the smart_run PMU/debug logic, driving the TMS wire that the target TAP2 decoder samples on posedge tclk.
- Generates the TAP2 reset sequence and the packet fields START, RnW, RS[1:0], TRN1, SYNC (reads only), DATA, PARITY and TRN2.
- For reads, releases the wire and captures target-driven data and parity.

Parameters:
- RST_CYCLES, 81: consecutive TMS-high cycles emitted for a TAP2 reset. Target resets on its 81st consecutive high sample.
- DR_LEN, 32: DATA length when rs = 01 or 11.
- IR_LEN, 8: DATA length when rs = 00 or 10.

Ports:
- tclk  input  1  TAP2 clock; all state updates on posedge.
- trst_b  input  1  reset, asynchronous, active-low.
- req_vld  input  1  access request valid.
- req_rdy  output  1  high only in IDLE with no reset sequence pending.
- req_rw  input  1  1 = read, 0 = write; sent as RnW bit.
- req_rs  input  2  register group select.
- req_wdata  input  32  write data; only the low IR_LEN bits are used for IR accesses.
- rst_req  input  1  one-cycle pulse requesting a TAP2 reset sequence.
- tms_o  output  1  registered TMS drive value.
- tms_oe  output  1  registered TMS output enable (1 = host drives).
- tms_i  input  1  TMS wire value sampled during read phases.
- rsp_vld  output  1  one-cycle pulse at access completion.
- rsp_rdata  output  32  read data, zero-extended for IR reads; holds until the next read completes.
- rsp_par_err  output  1  read parity mismatch flag, valid with rsp_vld.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: tms_o=1, tms_oe=1, rsp_vld=0, rsp_rdata=0, rsp_par_err=0, busy=0, state IDLE. trst_b low mid-packet aborts immediately to IDLE with these values.
- States: IDLE, RSTSEQ, START, RW, RS, TRN1, SYNC, DATA, PARITY, TRN2.
- IDLE
  - Drives tms_o=1, tms_oe=1.
  - rst_req=1 -> RSTSEQ. rst_req has priority over a simultaneous req_vld; that request is not accepted.
  - Otherwise req_vld=1 -> latch rw, rs and wdata; go to START.
  - Length select: len = DR_LEN if rs[0]=1, else IR_LEN.
- RSTSEQ: tms_o=1 for RST_CYCLES cycles (7-bit down-counter), then IDLE. rsp_vld is not pulsed.
- START: 1 cycle, tms_o=0.
- RW: 1 cycle, tms_o=rw.
- RS: 2 cycles, tms_o=rs[0] then rs[1] (LSB first).
- TRN1: 1 cycle, tms_o=1.
  - Read: tms_oe=0 here and through TRN2.
  - Write: tms_oe=1.
  - Next state: SYNC if read, else DATA.
- SYNC: 1 cycle, released, nothing sampled.
- DATA: len cycles, LSB first.
  - Write: tms_o = wdata[bit].
  - Read: tms_i sampled at the posedge ending each cycle, shifted in LSB-first.
  - 8-bit bit counter loaded len-1; DATA ends when it equals 0.
- PARITY: 1 cycle.
  - Parity is even: parity bit = XOR of the len data bits.
  - Write: driven.
  - Read: tms_i sampled.
- TRN2: 1 cycle.
  - Write: tms_o=1, oe=1.
  - Read: oe=0.
  - Then IDLE; oe returns to 1 with tms_o=1.
- Timing:
  - Outputs are registered; a request accepted at edge k shows the START bit in cycle k+1.
  - Packet length: write len+7 cycles, read len+8 cycles.
  - rsp_vld pulses on the first IDLE cycle after TRN2 for both reads and writes.
  - The next request can be accepted in that same IDLE cycle, giving back-to-back packets with one idle-high cycle between them.
- Read data: rsp_rdata is updated only on read completion.
- Target interaction: a high idle bit between packets keeps the target in its START wait. Holding tms_o high in IDLE never reaches 81 consecutive cycles unless the host stays idle for that long, which is harmless (target reset, then re-arm).

Optional Feature:
- Macro: TAP2_HOST_PAR_CHK_EN.
- Defined:
  - On read PARITY, compare sampled tms_i with the XOR of the captured data.
  - rsp_par_err=1 with rsp_vld on mismatch.
  - Writes always report 0.
- Not defined: no comparison logic; rsp_par_err tied 0.

Test Plan:
- Reset then rst_req pulse -> tms_o=1 for exactly 81 cycles, req_rdy=0 during them; a target decoder model is in RESET afterwards.
- Write rs=01, wdata=0xA5A5_0F0F -> tms_o sequence 0,0,1,0,1, then 32 data bits LSB-first, parity 0, then 1; 39 cycles total; rsp_vld one cycle later; target model reports write.
- Write rs=00, wdata=0x0000_0081 -> 8 data bits 1,0,0,0,0,0,0,1, parity 0; 15 cycles total.
- Read rs=11, target drives 0x1234_5678 with parity 1 -> tms_oe=0 from TRN1 through TRN2; rsp_rdata=0x1234_5678, rsp_par_err=0; 40 cycles total.
- Read with corrupted parity under TAP2_HOST_PAR_CHK_EN -> rsp_par_err=1; without the macro -> rsp_par_err=0.
- trst_b asserted mid-DATA of a read -> immediate IDLE, tms_oe=1, tms_o=1, rsp_vld never pulsed; rst_req and req_vld in the same cycle -> reset sequence runs, request not accepted until IDLE returns.
